gobou_serial: RTL

GOBOU_SERIAL -- requirements
Module: gobou_serial

---
 rtl/gobou_serial_pkg.sv | 9 +
 rtl/gobou_serial_buf.sv | 29 ++
 rtl/gobou_serial.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gobou_serial_pkg.sv
// Shared gobou parameters and serializer state encodings.
package gobou_serial_pkg;
  localparam int GOBOU_DWIDTH_DEF  = 16;
  localparam int GOBOU_CORE_DEF    = 16;
  localparam int GOBOU_CORELOG_DEF = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
endpackage

// File: rtl/gobou_serial_buf.sv
// One lane-group register: packed lane data plus its clamped lane count.
// Captures on load; otherwise holds. Cleared by asynchronous reset.
module gobou_serial_buf
  import gobou_serial_pkg::*;
#(
  parameter int DWIDTH        = GOBOU_DWIDTH_DEF,
  parameter int GOBOU_CORE    = GOBOU_CORE_DEF,
  parameter int GOBOU_CORELOG = GOBOU_CORELOG_DEF
) (
  input  logic                           clk,
  input  logic                           xrst,
  input  logic                           load,
  input  logic [GOBOU_CORE*DWIDTH-1:0]   load_data,
  input  logic [GOBOU_CORELOG:0]         load_cnt,
  output logic [GOBOU_CORE*DWIDTH-1:0]   data,
  output logic [GOBOU_CORELOG:0]         cnt
);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= load_cnt;
    end
  end

endmodule

// File: rtl/gobou_serial.sv
// Lane-group serializer: loads GOBOU_CORE lanes, emits lane_cnt beats, first beat 1 cycle after load.
// Valid/ready output; GOBOU_SERIAL_SKID_EN adds a second group buffer so one load can queue behind the current group.
module gobou_serial
  import gobou_serial_pkg::*;
#(
  parameter int DWIDTH        = GOBOU_DWIDTH_DEF,
  parameter int GOBOU_CORE    = GOBOU_CORE_DEF,
  parameter int GOBOU_CORELOG = GOBOU_CORELOG_DEF
) (
  input  logic                          clk,
  input  logic                          xrst,
  input  logic                          serial_we,
  input  logic [GOBOU_CORE*DWIDTH-1:0]  in_data,
  input  logic [GOBOU_CORELOG:0]        lane_cnt,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic signed [DWIDTH-1:0]      write_result,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun
);

  localparam int CW = GOBOU_CORELOG + 1;
  localparam int IW = GOBOU_CORELOG;
  localparam int GW = GOBOU_CORE * DWIDTH;
  localparam logic [CW-1:0] CORE_CNT = CW'(GOBOU_CORE);
`ifdef GOBOU_SERIAL_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  logic [0:0]    state_q;
  logic [IW-1:0] idx_q;
  logic          overrun_q;
  logic          skid_full_q, skid_full_d;
  logic [CW-1:0] cnt_clamp;
  logic          load_req, beat_acc, final_beat;
  logic          restart, go_idle, set_overrun;
  logic          buf0_ld;
  logic [GW-1:0] buf0_din, cur_data, skid_data;
  logic [CW-1:0] buf0_cin, cur_cnt, skid_cnt;

  assign cnt_clamp  = (lane_cnt > CORE_CNT) ? CORE_CNT : lane_cnt;
  assign load_req   = serial_we && (lane_cnt != '0);
  assign out_valid  = (state_q == ST_SHIFT);
  assign out_last   = out_valid && ({1'b0, idx_q} == (cur_cnt - CW'(1)));
  assign beat_acc   = out_valid && out_ready;
  assign final_beat = beat_acc && out_last;
  assign busy       = out_valid;
  assign overrun    = overrun_q;
  assign write_result = out_valid ? cur_data[idx_q*DWIDTH +: DWIDTH] : '0;

  // A load that lands on the final-beat handshake refills the active buffer with no bubble.
  always_comb begin
    buf0_ld     = 1'b0;
    buf0_din    = in_data;
    buf0_cin    = cnt_clamp;
    skid_full_d = skid_full_q;
    restart     = 1'b0;
    go_idle     = 1'b0;
    set_overrun = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load_req) begin
        buf0_ld = 1'b1;
        restart = 1'b1;
      end
    end else if (final_beat) begin
      if (skid_full_q) begin
        buf0_ld     = 1'b1;
        buf0_din    = skid_data;
        buf0_cin    = skid_cnt;
        restart     = 1'b1;
        skid_full_d = load_req;
      end else if (load_req) begin
        buf0_ld = 1'b1;
        restart = 1'b1;
      end else begin
        go_idle = 1'b1;
      end
    end else if (load_req) begin
      if (SKID_EN && !skid_full_q) skid_full_d = 1'b1;
      else                         set_overrun = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      overrun_q   <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      skid_full_q <= skid_full_d;
      overrun_q   <= overrun_q | set_overrun;
      if (restart) begin
        state_q <= ST_SHIFT;
        idx_q   <= '0;
      end else if (go_idle) begin
        state_q <= ST_IDLE;
        idx_q   <= '0;
      end else if (beat_acc) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  gobou_serial_buf #(.DWIDTH(DWIDTH), .GOBOU_CORE(GOBOU_CORE), .GOBOU_CORELOG(GOBOU_CORELOG)) u_buf0 (
    .clk(clk), .xrst(xrst), .load(buf0_ld), .load_data(buf0_din), .load_cnt(buf0_cin),
    .data(cur_data), .cnt(cur_cnt)
  );

`ifdef GOBOU_SERIAL_SKID_EN
  logic skid_ld;
  assign skid_ld = load_req && (state_q == ST_SHIFT) && (final_beat ? skid_full_q : !skid_full_q);

  gobou_serial_buf #(.DWIDTH(DWIDTH), .GOBOU_CORE(GOBOU_CORE), .GOBOU_CORELOG(GOBOU_CORELOG)) u_buf1 (
    .clk(clk), .xrst(xrst), .load(skid_ld), .load_data(in_data), .load_cnt(cnt_clamp),
    .data(skid_data), .cnt(skid_cnt)
  );
`else
  assign skid_data = '0;
  assign skid_cnt  = '0;
`endif

endmodule
